// File: rtl/ulpi_reg_write.sv
// ULPI immediate register write engine.
// Issues a RegWrite TXCMD and the data byte, then a one-cycle STP. The write is
// abandoned without STP if the PHY takes the bus (DIR=1) before the data is accepted.
module ulpi_reg_write (
  input  logic       clk,
  input  logic       rst,
  input  logic       WD,
  input  logic [5:0] ADDR,
  input  logic [7:0] DATA,
  output logic       busy,
  input  logic       DIR,
  output logic       STP,
  input  logic       NXT,
  inout  wire  [7:0] ULPI_DATA
);

  typedef enum logic [1:0] {
    StIdle,
    StCmd,
    StWdata,
    StStop
  } state_e;

  state_e     state_q, state_d;
  logic [5:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;

  logic       busy_q, busy_d;
  logic       stp_q, stp_d;
  logic       oe_q, oe_d;
  logic [7:0] bus_q, bus_d;

  // Next-state, request latching and next output values.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;

    unique case (state_q)
      StIdle: begin
        // Requests while the PHY owns the bus are dropped, not queued.
        if (WD && !DIR) begin
          state_d = StCmd;
          addr_d  = ADDR;
          data_d  = DATA;
        end
      end
      StCmd: begin
        if (DIR) begin
          state_d = StIdle;
        end else if (NXT) begin
          state_d = StWdata;
        end
      end
      StWdata: begin
        if (DIR) begin
          state_d = StIdle;
        end else if (NXT) begin
          state_d = StStop;
        end
      end
      StStop: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Outputs are decoded from the next state so they are registered yet
    // line up with the state they belong to.
    busy_d = (state_d != StIdle);
    stp_d  = (state_d == StStop);
    oe_d   = busy_d;
    unique case (state_d)
      StCmd:   bus_d = {2'b10, addr_d};
      StWdata: bus_d = data_d;
      default: bus_d = 8'h00;
    endcase
  end

  // State and latched request registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= 6'h00;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      stp_q  <= 1'b0;
      oe_q   <= 1'b0;
      bus_q  <= 8'h00;
    end else begin
      busy_q <= busy_d;
      stp_q  <= stp_d;
      oe_q   <= oe_d;
      bus_q  <= bus_d;
    end
  end

  assign busy = busy_q;
  assign STP  = stp_q;

  // Live DIR gating: the link must let go the moment the PHY turns the bus around.
  assign ULPI_DATA = (oe_q && !DIR) ? bus_q : 8'hzz;

endmodule

// File: tb/tb_ulpi_reg_write.sv
// Self-checking bench for ulpi_reg_write: directed scenarios plus random traffic,
// checked against a transaction-level model (queue of bytes still owed to the bus).
module tb_ulpi_reg_write;

  localparam logic [7:0] PhyByte = 8'h5A;  // value the PHY drives while DIR=1
  localparam logic [7:0] Floated = 8'hFF;  // released bus reads the pull-up

  logic       clk = 1'b0;
  logic       rst;
  logic       wd;
  logic [5:0] addr;
  logic [7:0] data;
  logic       busy;
  logic       dir;
  logic       stp;
  logic       nxt;
  wire  [7:0] ulpi_data;

  int n_checks = 0;
  int n_pass   = 0;

  // Bytes the link still has to present: TXCMD, data, then the STOP byte.
  logic [7:0] exp_q[$];

  ulpi_reg_write dut (
    .clk       (clk),
    .rst       (rst),
    .WD        (wd),
    .ADDR      (addr),
    .DATA      (data),
    .busy      (busy),
    .DIR       (dir),
    .STP       (stp),
    .NXT       (nxt),
    .ULPI_DATA (ulpi_data)
  );

  // PHY side of the bus: drives when it owns it, otherwise a pull-up shows release.
  assign ulpi_data = dir ? PhyByte : 8'hzz;
  pullup (ulpi_data);

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %02h, expected %02h", tag, got, exp);
    end
  endtask

  // Advance the reference by one clock edge using the inputs the DUT sees.
  task automatic model_step();
    if (exp_q.size() == 0) begin
      if (wd && !dir) exp_q = '{{2'b10, addr}, data, 8'h00};
    end else if (exp_q.size() == 1) begin
      exp_q.delete();
    end else if (dir) begin
      exp_q.delete();
    end else if (nxt) begin
      void'(exp_q.pop_front());
    end
  endtask

  task automatic compare(input string tag);
    logic [7:0] exp_bus;
    if (dir) exp_bus = PhyByte;
    else if (exp_q.size() != 0) exp_bus = exp_q[0];
    else exp_bus = Floated;
    check_eq({tag, "_busy"}, {7'd0, busy}, {7'd0, exp_q.size() != 0});
    check_eq({tag, "_stp"}, {7'd0, stp}, {7'd0, exp_q.size() == 1});
    check_eq({tag, "_bus"}, ulpi_data, exp_bus);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare(tag);
  endtask

  task automatic set_in(input logic w, input logic [5:0] a, input logic [7:0] d,
                        input logic di, input logic n);
    wd = w; addr = a; data = d; dir = di; nxt = n;
  endtask

  // Asynchronous reset pulse between edges; outputs must clear before any edge.
  task automatic reset_pulse(input string tag);
    #2 rst = 1'b1;
    #1;
    check_eq({tag, "_rbusy"}, {7'd0, busy}, 8'd0);
    check_eq({tag, "_rstp"}, {7'd0, stp}, 8'd0);
    check_eq({tag, "_rbus"}, ulpi_data, dir ? PhyByte : Floated);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    set_in(1'b0, 6'h00, 8'h00, 1'b0, 1'b0);
    #2;
    check_eq("reset_busy", {7'd0, busy}, 8'd0);
    check_eq("reset_stp", {7'd0, stp}, 8'd0);
    check_eq("reset_bus", ulpi_data, Floated);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tick("idle");

    // Basic write, NXT high for two cycles starting one cycle into CMD.
    set_in(1'b1, 6'h1A, 8'h3A, 1'b0, 1'b0); tick("w1_acc");
    check_eq("w1_txcmd", ulpi_data, 8'h9A);
    set_in(1'b0, 6'h00, 8'h00, 1'b0, 1'b0); tick("w1_cmd");
    check_eq("w1_txcmd_hold", ulpi_data, 8'h9A);
    nxt = 1'b1; tick("w1_nxt1");
    check_eq("w1_data", ulpi_data, 8'h3A);
    tick("w1_nxt2");
    check_eq("w1_stop_bus", ulpi_data, 8'h00);
    check_eq("w1_stop_stp", {7'd0, stp}, 8'd1);
    nxt = 1'b0; tick("w1_done");
    check_eq("w1_idle_busy", {7'd0, busy}, 8'd0);

    // Throttled: NXT low for ten cycles, then complete.
    set_in(1'b1, 6'h1A, 8'h3A, 1'b0, 1'b0); tick("w2_acc");
    wd = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick("w2_wait");
      check_eq("w2_wait_bus", ulpi_data, 8'h9A);
    end
    nxt = 1'b1; tick("w2_nxt1"); tick("w2_nxt2");
    nxt = 1'b0; tick("w2_done");

    // Second request while busy is ignored.
    set_in(1'b1, 6'h1A, 8'h3A, 1'b0, 1'b0); tick("w3_acc");
    set_in(1'b1, 6'h05, 8'h77, 1'b0, 1'b0); tick("w3_ign");
    check_eq("w3_keep_addr", ulpi_data, 8'h9A);
    set_in(1'b0, 6'h05, 8'h77, 1'b0, 1'b1); tick("w3_nxt1");
    check_eq("w3_keep_data", ulpi_data, 8'h3A);
    tick("w3_stop");
    nxt = 1'b0; tick("w3_done");

    // PHY takes the bus during WDATA: abort, no STP.
    set_in(1'b1, 6'h1A, 8'h3A, 1'b0, 1'b1); tick("w4_acc");
    wd = 1'b0; tick("w4_wdata");
    set_in(1'b0, 6'h00, 8'h00, 1'b1, 1'b0); tick("w4_dir");
    check_eq("w4_abort_busy", {7'd0, busy}, 8'd0);
    check_eq("w4_abort_stp", {7'd0, stp}, 8'd0);
    dir = 1'b0; tick("w4_idle");
    check_eq("w4_released", ulpi_data, Floated);

    // Reset mid-CMD, then a fresh transaction.
    set_in(1'b1, 6'h1A, 8'h3A, 1'b0, 1'b0); tick("w5_acc");
    wd = 1'b0;
    reset_pulse("w5");
    set_in(1'b1, 6'h3F, 8'hFF, 1'b0, 1'b0); tick("w5_acc2");
    check_eq("w5_txcmd", ulpi_data, 8'hBF);
    set_in(1'b0, 6'h00, 8'h00, 1'b0, 1'b1); tick("w5_data");
    check_eq("w5_data_bus", ulpi_data, 8'hFF);
    tick("w5_stop");
    nxt = 1'b0; tick("w5_done");

    // Request while DIR=1 is dropped.
    set_in(1'b1, 6'h1A, 8'h3A, 1'b1, 1'b0); tick("w6_dir");
    check_eq("w6_busy", {7'd0, busy}, 8'd0);
    set_in(1'b0, 6'h00, 8'h00, 1'b0, 1'b0); tick("w6_idle");

    // Random traffic with occasional asynchronous resets.
    for (int i = 0; i < 1500; i++) begin
      set_in($urandom_range(3) == 0, 6'($urandom), 8'($urandom),
             $urandom_range(7) == 0, 1'($urandom_range(1)));
      tick("rnd");
      if ($urandom_range(99) == 0) reset_pulse("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
